// File: rtl/clk_div_pkg.sv
// Shared constants and types for the clock divider bank.
package clk_div_pkg;

    localparam int CNT_W_DEF       = 16;
    localparam int NUM_CH_DEF      = 4;
    localparam int DEFAULT_DIV_DEF = 50;

    typedef logic [CNT_W_DEF-1:0] div_t;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, active/pending divisor, registered
// divided clock and once-per-period tick strobe.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_div_i,
    output logic             clk_out_o,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W:0]   ONE     = (CNT_W+1)'(1);

    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    logic             pend_n;
    logic             wrap;
    logic             apply;
    logic [CNT_W:0]   half;

    always_comb begin
        pdiv_d = wr_i ? wr_div_i : pdiv_q;
        pend_n = wr_i | pend_q;
        wrap   = en_i && (cnt_q >= (div_q - 1'b1));
        // A new divisor only lands at a period boundary: wrap, idle or resync.
        apply  = !en_i || wrap || sync_i;
        div_d  = (apply && pend_n) ? pdiv_d : div_q;
        pend_d = pend_n && !apply;

        if (!en_i || sync_i || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        tick_d = wrap && !sync_i;
        // Rounding the half-period up makes odd divisors spend the extra cycle high.
        half   = ({1'b0, div_d} + ONE) >> 1;
        clk_d  = en_i && ({1'b0, cnt_d} < half);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= DIV_RST;
            pdiv_q <= DIV_RST;
            pend_q <= 1'b0;
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            pdiv_q <= pdiv_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_out_o = clk_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent clock dividers with a shared divisor-write port.
// Optional macro CLK_DIV_SYNC_EN adds a 'sync' input that realigns all channels.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter  int NUM_CH      = NUM_CH_DEF,
    parameter  int CNT_W       = CNT_W_DEF,
    parameter  int DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
`ifdef CLK_DIV_SYNC_EN
    input  logic              sync,
`endif
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

    logic              accept;
    logic              bad_wr;
    logic              cfg_err_q, cfg_err_d;
    logic              sync_int;
    logic [NUM_CH-1:0] wr;

    // Writes are accepted on every cycle outside reset; there is no backpressure.
    assign cfg_ready = rst;
    assign accept    = cfg_valid && cfg_ready;
    assign bad_wr    = (cfg_div == '0) || ({1'b0, cfg_ch} >= NUM_CH_L);
    assign cfg_err_d = accept && bad_wr;

`ifdef CLK_DIV_SYNC_EN
    assign sync_int = sync;
`else
    assign sync_int = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [CH_W-1:0] IDX = CH_W'(i);

        assign wr[i] = accept && !bad_wr && (cfg_ch == IDX);

        clk_div_ch #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst),
            .en_i     (en[i]),
            .sync_i   (sync_int),
            .wr_i     (wr[i]),
            .wr_div_i (cfg_div),
            .clk_out_o(clk_out[i]),
            .tick_o   (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: a 4-channel default instance plus a
// 3-channel instance so an out-of-range channel index is expressible.
module tb_clk_div_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic        cfg_err;
    logic [3:0]  clk_out;
    logic [3:0]  tick;

    logic [2:0]  en2;
    logic        cfg2_valid;
    logic        cfg2_ready;
    logic [1:0]  cfg2_ch;
    logic [7:0]  cfg2_div;
    logic        cfg2_err;
    logic [2:0]  clk_out2;
    logic [2:0]  tick2;

`ifdef CLK_DIV_SYNC_EN
    logic        sync;
`endif

    int    total = 0;
    int    bad   = 0;
    string qn[$];
    int    qv[$];

    clk_div_bank dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
`ifdef CLK_DIV_SYNC_EN
        .sync     (sync),
`endif
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_err  (cfg_err),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    clk_div_bank #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(4)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .en       (en2),
`ifdef CLK_DIV_SYNC_EN
        .sync     (1'b0),
`endif
        .cfg_valid(cfg2_valid),
        .cfg_ready(cfg2_ready),
        .cfg_ch   (cfg2_ch),
        .cfg_div  (cfg2_div),
        .cfg_err  (cfg2_err),
        .clk_out  (clk_out2),
        .tick     (tick2)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int ch, output int n);
        n = -1;
        for (int k = 1; k <= 300; k++) begin
            step(1);
            if (tick[ch] === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wait_tick2(output int n);
        n = -1;
        for (int k = 1; k <= 300; k++) begin
            step(1);
            if (tick2[0] === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic measure_hilo(input int ch, output int hi, output int lo);
        hi = 0;
        lo = 0;
        while (clk_out[ch] === 1'b1 && hi < 300) begin
            hi++;
            step(1);
        end
        while (clk_out[ch] === 1'b0 && lo < 300) begin
            lo++;
            step(1);
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [15:0] div);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = div;
    endtask

    task automatic test_reset;
        rst = 1'b0; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        en2 = '0; cfg2_valid = 1'b0; cfg2_ch = '0; cfg2_div = '0;
`ifdef CLK_DIV_SYNC_EN
        sync = 1'b0;
`endif
        step(3);
        total++;
        if (clk_out !== 4'b0 || tick !== 4'b0) begin
            bad++; $display("FAIL reset_outputs: clk_out=%b tick=%b, want 0000/0000", clk_out, tick);
        end
        total++;
        if (cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
            bad++; $display("FAIL reset_cfg: ready=%b err=%b, want 0/0", cfg_ready, cfg_err);
        end
        rst = 1'b1;
        en2 = 3'b001;
        #1;
        total++;
        if (cfg_ready !== 1'b1) begin
            bad++; $display("FAIL ready_after_release: got %b, want 1", cfg_ready);
        end
        step(1);
    endtask

    task automatic test_d50;
        int n, hi, lo, ev;
        logic [5:0] acc;
        en = 4'b0001;
        qn.push_back("d50_first"); qv.push_back(50);
        wait_tick(0, n);
        total++; ev = qv.pop_front();
        if (n !== ev) begin bad++; $display("FAIL %s: got %0d, want %0d", qn.pop_front(), n, ev); end
        else void'(qn.pop_front());
        qn.push_back("d50_high"); qv.push_back(25);
        qn.push_back("d50_low");  qv.push_back(25);
        measure_hilo(0, hi, lo);
        total++; ev = qv.pop_front();
        if (hi !== ev) begin bad++; $display("FAIL %s: got %0d, want %0d", qn.pop_front(), hi, ev); end
        else void'(qn.pop_front());
        total++; ev = qv.pop_front();
        if (lo !== ev) begin bad++; $display("FAIL %s: got %0d, want %0d", qn.pop_front(), lo, ev); end
        else void'(qn.pop_front());
        acc = '0;
        for (int k = 0; k < 60; k++) begin
            step(1);
            acc = acc | {clk_out[3:1], tick[3:1]};
        end
        total++;
        if (acc !== 6'b0) begin bad++; $display("FAIL idle_channels_quiet: got %b, want 000000", acc); end
    endtask

    task automatic test_pending;
        int n, ev;
        wait_tick(0, n);
        step(20);
        cfg_write(2'd0, 16'd10);
        step(1);
        cfg_valid = 1'b0;
        qn.push_back("pend_finish"); qv.push_back(29);
        qn.push_back("pend_new");    qv.push_back(10);
        for (int r = 0; r < 2; r++) begin
            wait_tick(0, n);
            total++; ev = qv.pop_front();
            if (n !== ev) begin bad++; $display("FAIL %s: got %0d, want %0d", qn.pop_front(), n, ev); end
            else void'(qn.pop_front());
        end
        step(2);
        cfg_write(2'd0, 16'd8);
        step(1);
        cfg_div = 16'd12;
        step(1);
        cfg_valid = 1'b0;
        qn.push_back("pend_cur");  qv.push_back(6);
        qn.push_back("pend_last"); qv.push_back(12);
        for (int r = 0; r < 2; r++) begin
            wait_tick(0, n);
            total++; ev = qv.pop_front();
            if (n !== ev) begin bad++; $display("FAIL %s: got %0d, want %0d", qn.pop_front(), n, ev); end
            else void'(qn.pop_front());
        end
    endtask

    task automatic test_d5_d1;
        int n, hi, lo, ev, acc;
        cfg_write(2'd1, 16'd5);
        step(1);
        cfg_valid = 1'b0;
        en = 4'b0011;
        qn.push_back("d5_first"); qv.push_back(5);
        qn.push_back("d5_high");  qv.push_back(3);
        qn.push_back("d5_low");   qv.push_back(2);
        wait_tick(1, n);
        total++; ev = qv.pop_front();
        if (n !== ev) begin bad++; $display("FAIL %s: got %0d, want %0d", qn.pop_front(), n, ev); end
        else void'(qn.pop_front());
        measure_hilo(1, hi, lo);
        total++; ev = qv.pop_front();
        if (hi !== ev) begin bad++; $display("FAIL %s: got %0d, want %0d", qn.pop_front(), hi, ev); end
        else void'(qn.pop_front());
        total++; ev = qv.pop_front();
        if (lo !== ev) begin bad++; $display("FAIL %s: got %0d, want %0d", qn.pop_front(), lo, ev); end
        else void'(qn.pop_front());
        en = 4'b0001;
        cfg_write(2'd1, 16'd1);
        step(1);
        cfg_valid = 1'b0;
        en = 4'b0011;
        qn.push_back("d1_always_high"); qv.push_back(8);
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            step(1);
            if (tick[1] === 1'b1 && clk_out[1] === 1'b1) acc++;
        end
        total++; ev = qv.pop_front();
        if (acc !== ev) begin bad++; $display("FAIL %s: got %0d, want %0d", qn.pop_front(), acc, ev); end
        else void'(qn.pop_front());
    endtask

    task automatic test_independent;
        int n, ev, tk, hi;
        en = 4'b0001;
        cfg_write(2'd1, 16'd5);
        step(1);
        cfg_valid = 1'b0;
        en = 4'b0011;
        qn.push_back("d5_relaunch"); qv.push_back(5);
        wait_tick(1, n);
        total++; ev = qv.pop_front();
        if (n !== ev) begin bad++; $display("FAIL %s: got %0d, want %0d", qn.pop_front(), n, ev); end
        else void'(qn.pop_front());
        qn.push_back("indep_ticks"); qv.push_back(4);
        qn.push_back("indep_high");  qv.push_back(12);
        cfg_write(2'd0, 16'd12);
        tk = 0; hi = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (tick[1] === 1'b1) tk++;
            if (clk_out[1] === 1'b1) hi++;
        end
        cfg_valid = 1'b0;
        total++; ev = qv.pop_front();
        if (tk !== ev) begin bad++; $display("FAIL %s: got %0d, want %0d", qn.pop_front(), tk, ev); end
        else void'(qn.pop_front());
        total++; ev = qv.pop_front();
        if (hi !== ev) begin bad++; $display("FAIL %s: got %0d, want %0d", qn.pop_front(), hi, ev); end
        else void'(qn.pop_front());
    endtask

    task automatic test_cfg_err;
        int n, ev;
        total++;
        if (cfg_ready !== 1'b1) begin bad++; $display("FAIL ready_running: got %b, want 1", cfg_ready); end
        cfg_write(2'd0, 16'd0);
        step(1);
        cfg_valid = 1'b0;
        total++;
        if (cfg_err !== 1'b1) begin bad++; $display("FAIL err_div0_pulse: got %b, want 1", cfg_err); end
        step(1);
        total++;
        if (cfg_err !== 1'b0) begin bad++; $display("FAIL err_div0_clear: got %b, want 0", cfg_err); end
        qn.push_back("err_period_kept"); qv.push_back(12);
        wait_tick(0, n);
        wait_tick(0, n);
        total++; ev = qv.pop_front();
        if (n !== ev) begin bad++; $display("FAIL %s: got %0d, want %0d", qn.pop_front(), n, ev); end
        else void'(qn.pop_front());
        cfg2_valid = 1'b1; cfg2_ch = 2'd3; cfg2_div = 8'd2;
        step(1);
        cfg2_valid = 1'b0;
        total++;
        if (cfg2_err !== 1'b1) begin bad++; $display("FAIL err_badch_pulse: got %b, want 1", cfg2_err); end
        step(1);
        total++;
        if (cfg2_err !== 1'b0) begin bad++; $display("FAIL err_badch_clear: got %b, want 0", cfg2_err); end
        qn.push_back("badch_period_kept"); qv.push_back(4);
        wait_tick2(n);
        wait_tick2(n);
        total++; ev = qv.pop_front();
        if (n !== ev) begin bad++; $display("FAIL %s: got %0d, want %0d", qn.pop_front(), n, ev); end
        else void'(qn.pop_front());
    endtask

    task automatic test_reset_mid;
        int n, ev, f0, s0, f1, f2;
        wait_tick(0, n);
        step(2);
        cfg_write(2'd0, 16'd20);
        step(1);
        cfg_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        total++;
        if (clk_out !== 4'b0 || tick !== 4'b0 || clk_out2 !== 3'b0) begin
            bad++; $display("FAIL async_reset_out: clk_out=%b tick=%b clk_out2=%b, want all 0", clk_out, tick, clk_out2);
        end
        total++;
        if (cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
            bad++; $display("FAIL async_reset_cfg: ready=%b err=%b, want 0/0", cfg_ready, cfg_err);
        end
        step(2);
        rst = 1'b1;
        qn.push_back("rst_ch0_first");  qv.push_back(50);
        qn.push_back("rst_ch0_second"); qv.push_back(100);
        qn.push_back("rst_ch1_first");  qv.push_back(50);
        qn.push_back("rst_dut2_first"); qv.push_back(4);
        f0 = -1; s0 = -1; f1 = -1; f2 = -1;
        for (int k = 1; k <= 120; k++) begin
            step(1);
            if (tick[0] === 1'b1) begin
                if (f0 < 0) f0 = k;
                else if (s0 < 0) s0 = k;
            end
            if (tick[1] === 1'b1 && f1 < 0) f1 = k;
            if (tick2[0] === 1'b1 && f2 < 0) f2 = k;
        end
        total++; ev = qv.pop_front();
        if (f0 !== ev) begin bad++; $display("FAIL %s: got %0d, want %0d", qn.pop_front(), f0, ev); end
        else void'(qn.pop_front());
        total++; ev = qv.pop_front();
        if (s0 !== ev) begin bad++; $display("FAIL %s: got %0d, want %0d", qn.pop_front(), s0, ev); end
        else void'(qn.pop_front());
        total++; ev = qv.pop_front();
        if (f1 !== ev) begin bad++; $display("FAIL %s: got %0d, want %0d", qn.pop_front(), f1, ev); end
        else void'(qn.pop_front());
        total++; ev = qv.pop_front();
        if (f2 !== ev) begin bad++; $display("FAIL %s: got %0d, want %0d", qn.pop_front(), f2, ev); end
        else void'(qn.pop_front());
    endtask

`ifdef CLK_DIV_SYNC_EN
    task automatic test_sync;
        int ev, f0, f1;
        en = 4'b0000;
        step(1);
        cfg_write(2'd0, 16'd6);
        step(1);
        cfg_write(2'd1, 16'd4);
        step(1);
        cfg_valid = 1'b0;
        en = 4'b0001;
        step(2);
        en = 4'b0011;
        step(3);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        total++;
        if (tick !== 4'b0) begin bad++; $display("FAIL sync_tick_suppressed: got %b, want 0000", tick); end
        qn.push_back("sync_ch0_first"); qv.push_back(6);
        qn.push_back("sync_ch1_first"); qv.push_back(4);
        f0 = -1; f1 = -1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (tick[0] === 1'b1 && f0 < 0) f0 = k;
            if (tick[1] === 1'b1 && f1 < 0) f1 = k;
        end
        total++; ev = qv.pop_front();
        if (f0 !== ev) begin bad++; $display("FAIL %s: got %0d, want %0d", qn.pop_front(), f0, ev); end
        else void'(qn.pop_front());
        total++; ev = qv.pop_front();
        if (f1 !== ev) begin bad++; $display("FAIL %s: got %0d, want %0d", qn.pop_front(), f1, ev); end
        else void'(qn.pop_front());
    endtask
`endif

    initial begin
        test_reset();
        test_d50();
        test_pending();
        test_d5_d1();
        test_independent();
        test_cfg_err();
        test_reset_mid();
`ifdef CLK_DIV_SYNC_EN
        test_sync();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
